// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR generator and the LFSR stream checker, so
// the two ends of the link always agree on the polynomial.
//   N_MAX        widest supported LFSR order
//   tap_mask()   Fibonacci tap mask (bit indices) for orders 2..N_MAX
//   chk_state_e  checker FSM encoding (2'd2/2'd3 unused)
//   lfsr_next()  one Fibonacci step for an order-n register held in N_MAX bits
// ---------------------------------------------------------------------------
package lfsr_pkg;

  localparam int N_MAX = 8;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_LOCKED  = 2'd1
  } chk_state_e;

  // Maximal-length tap table, indexed by LFSR order. Unsupported orders
  // return an empty mask.
  function automatic logic [N_MAX-1:0] tap_mask(input int n);
    logic [N_MAX-1:0] m;
    case (n)
      2:       m = 8'h03;
      3:       m = 8'h06;
      4:       m = 8'h0C;
      5:       m = 8'h14;
      6:       m = 8'h30;
      7:       m = 8'h60;
      8:       m = 8'hB8;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  // Shift left by one and feed the XOR of the tapped bits into bit 0.
  // Bits at and above n stay zero.
  function automatic logic [N_MAX-1:0] lfsr_next(input logic [N_MAX-1:0] x,
                                                 input int n);
    logic [N_MAX-1:0] r;
    r = '0;
    for (int i = 1; i < N_MAX; i++) begin
      if (i < n) r[i] = x[i-1];
    end
    r[0] = ^(x & tap_mask(n));
    return r;
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// ---------------------------------------------------------------------------
// lfsr_checker_if
// Word stream from the LFSR generator into the checker.
//   data_valid   data_in carries a stream word this cycle
//   data_in      N-bit generator word
// Modports: master = generator side, slave = checker side.
// ---------------------------------------------------------------------------
interface lfsr_checker_if #(
  parameter int N = 4
);

  logic         data_valid;
  logic [N-1:0] data_in;

  modport master (output data_valid, output data_in);
  modport slave  (input  data_valid, input  data_in);

endinterface

// File: rtl/lfsr_checker_next_comb.sv
// ---------------------------------------------------------------------------
// lfsr_next_comb
// Pure combinational Fibonacci LFSR step for an order-N register, using the
// shared tap table.
//   x   current word
//   y   next word in the sequence
// ---------------------------------------------------------------------------
module lfsr_next_comb
  import lfsr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  output logic [N-1:0] y
);

  localparam logic [N_MAX-1:0] MASK_W = tap_mask(N);
  localparam logic [N-1:0]     MASK   = MASK_W[N-1:0];

  assign y = {x[N-2:0], ^(x & MASK)};

endmodule

// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
// Self-synchronising checker for an LFSR word stream. It seeds its predictor
// from the incoming data, declares lock after LOCK_COUNT correct predictions,
// then flywheels on its own prediction, flagging and counting mismatches.
// UNLOCK_ERRS consecutive mismatches drop it back to acquisition. While locked
// it pulses period_done once every 2**N-1 valid words.
//   clk          clock, all logic on posedge
//   reset        synchronous active-high reset
//   clear        synchronous clear: back to ACQUIRE, counters zeroed
//   bus          stream input (data_valid, data_in)
//   locked       checker is synchronised to the stream
//   err_pulse    one-cycle pulse on a mismatched word while locked
//   err_count    saturating count of mismatches while locked
//   period_done  one-cycle pulse every full sequence period while locked
//   state        current FSM state (debug)
// ---------------------------------------------------------------------------
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int N           = 4,
  parameter int LOCK_COUNT  = 3,
  parameter int UNLOCK_ERRS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  lfsr_checker_if.slave        bus,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [15:0]          err_count,
  output logic                 period_done,
  output logic [1:0]           state
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);
  // Last period_cnt value before the wrap: 2**N-2.
  localparam logic [N-1:0] PERIOD_LAST = N'((1 << N) - 2);

  chk_state_e    state_q, state_d;
  logic [N-1:0]  expected_q, expected_d;
  logic [MW-1:0] match_cnt_q, match_cnt_d;
  logic [BW-1:0] bad_cnt_q, bad_cnt_d;
  logic [N-1:0]  period_cnt_q, period_cnt_d;
  logic          locked_q, locked_d;
  logic          err_pulse_q, err_pulse_d;
  logic [15:0]   err_count_q, err_count_d;
  logic          period_done_q, period_done_d;

  logic [N-1:0]  next_in, next_word;
  logic          word_ok;

  // Acquiring: predict from the received word. Locked: flywheel on our own
  // prediction so corrupted words never disturb the predictor.
  assign next_in = (state_q == ST_LOCKED) ? expected_q : bus.data_in;
  assign word_ok = (bus.data_in == expected_q);

  lfsr_next_comb #(.N(N)) u_next (
    .x (next_in),
    .y (next_word)
  );

  // expected=0 marks "no seed yet": a nonzero word can never equal it, so the
  // next accepted word always seeds the predictor.
  always_comb begin
    state_d       = state_q;
    expected_d    = expected_q;
    match_cnt_d   = match_cnt_q;
    bad_cnt_d     = bad_cnt_q;
    period_cnt_d  = period_cnt_q;
    locked_d      = locked_q;
    err_pulse_d   = 1'b0;
    err_count_d   = err_count_q;
    period_done_d = 1'b0;

    if (clear) begin
      state_d      = ST_ACQUIRE;
      expected_d   = '0;
      match_cnt_d  = '0;
      bad_cnt_d    = '0;
      period_cnt_d = '0;
      locked_d     = 1'b0;
      err_count_d  = '0;
    end else if (bus.data_valid) begin
      case (state_q)
        ST_LOCKED: begin
          expected_d = next_word;
          if (word_ok) begin
            bad_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            bad_cnt_d = bad_cnt_q + 1'b1;
          end
          if (period_cnt_q == PERIOD_LAST) begin
            period_done_d = 1'b1;
            period_cnt_d  = '0;
          end else begin
            period_cnt_d = period_cnt_q + 1'b1;
          end
          // Unlock still lets a coincident period wrap pulse above.
          if (!word_ok && (bad_cnt_q == BW'(UNLOCK_ERRS - 1))) begin
            state_d     = ST_ACQUIRE;
            locked_d    = 1'b0;
            match_cnt_d = '0;
            expected_d  = '0;
          end
        end
        default: begin
          if (bus.data_in == '0) begin
            // All-zero is the LFSR lock-up word and carries no phase info.
            match_cnt_d = '0;
          end else if (!word_ok) begin
            expected_d  = next_word;
            match_cnt_d = '0;
          end else begin
            expected_d = next_word;
            if (match_cnt_q == MW'(LOCK_COUNT - 1)) begin
              state_d      = ST_LOCKED;
              locked_d     = 1'b1;
              match_cnt_d  = '0;
              bad_cnt_d    = '0;
              period_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_ACQUIRE;
      expected_q    <= '0;
      match_cnt_q   <= '0;
      bad_cnt_q     <= '0;
      period_cnt_q  <= '0;
      locked_q      <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_count_q   <= '0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      expected_q    <= expected_d;
      match_cnt_q   <= match_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      period_cnt_q  <= period_cnt_d;
      locked_q      <= locked_d;
      err_pulse_q   <= err_pulse_d;
      err_count_q   <= err_count_d;
      period_done_q <= period_done_d;
    end
  end

  assign locked      = locked_q;
  assign err_pulse   = err_pulse_q;
  assign err_count   = err_count_q;
  assign period_done = period_done_q;
  assign state       = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker
// Bench for lfsr_checker at N=4, LOCK_COUNT=3, UNLOCK_ERRS=4. The reference
// model tracks the stream as a position in the literal 15-word maximal
// sequence of x^4+x^3+1, rather than stepping a shift register.
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

  localparam int N           = 4;
  localparam int LOCK_COUNT  = 3;
  localparam int UNLOCK_ERRS = 4;
  localparam int PERIOD      = 15;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        period_done;
  logic [1:0]  state;

  lfsr_checker_if #(.N(N)) bus ();

  lfsr_checker #(
    .N           (N),
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_ERRS (UNLOCK_ERRS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .bus         (bus),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_count   (err_count),
    .period_done (period_done),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // The full sequence starting from 0001.
  logic [3:0] seq [PERIOD];

  // Reference model state.
  bit m_locked, m_seeded, m_errp, m_pd;
  int m_pos, m_match, m_bad, m_period, m_errs;

  function automatic int idx_of(input logic [3:0] w);
    for (int i = 0; i < PERIOD; i++) if (seq[i] == w) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_seeded = 0; m_errp = 0; m_pd = 0;
    m_pos = 0; m_match = 0; m_bad = 0; m_period = 0; m_errs = 0;
  endtask

  task automatic model_step(input bit v, input logic [3:0] w);
    m_errp = 0;
    m_pd   = 0;
    if (!v) return;
    if (!m_locked) begin
      if (w == 4'd0) begin
        m_match = 0;
      end else if (m_seeded && w == seq[m_pos]) begin
        m_match++;
        m_pos = (m_pos + 1) % PERIOD;
        if (m_match == LOCK_COUNT) begin
          m_locked = 1; m_bad = 0; m_period = 0;
        end
      end else begin
        m_seeded = 1;
        m_pos    = (idx_of(w) + 1) % PERIOD;
        m_match  = 0;
      end
    end else begin
      if (w == seq[m_pos]) m_bad = 0;
      else begin
        m_errp = 1;
        if (m_errs < 65535) m_errs++;
        m_bad++;
      end
      m_pos = (m_pos + 1) % PERIOD;
      m_period++;
      if (m_period == PERIOD) begin m_pd = 1; m_period = 0; end
      if (m_bad == UNLOCK_ERRS) begin
        m_locked = 0; m_match = 0; m_seeded = 0;
      end
    end
  endtask

  // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic drive(input bit v, input logic [3:0] w, input bit c);
    @(negedge clk);
    bus.data_valid = v;
    bus.data_in    = w;
    clear          = c;
    @(posedge clk);
    if (c) begin
      m_locked = 0; m_seeded = 0; m_match = 0; m_bad = 0;
      m_period = 0; m_errs = 0; m_errp = 0; m_pd = 0;
    end else begin
      model_step(v, w);
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; clear = 0; bus.data_valid = 0; bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic acquire_from(input int s);
    for (int i = 0; i < 4; i++) drive(1, seq[(s + i) % PERIOD], 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (locked !== 1'b0) $display("[TB] FAIL reset_locked: got %0b want 0", locked); else n_pass++;
    n_total++; if (err_pulse !== 1'b0) $display("[TB] FAIL reset_err_pulse: got %0b want 0", err_pulse); else n_pass++;
    n_total++; if (err_count !== 16'd0) $display("[TB] FAIL reset_err_count: got %0d want 0", err_count); else n_pass++;
    n_total++; if (period_done !== 1'b0) $display("[TB] FAIL reset_period_done: got %0b want 0", period_done); else n_pass++;
    n_total++; if (state !== 2'd0) $display("[TB] FAIL reset_state: got %0d want 0", state); else n_pass++;
  endtask

  task automatic test_acquire();
    logic [3:0] words [4];
    words = '{4'b0001, 4'b0010, 4'b0100, 4'b1001};
    for (int i = 0; i < 4; i++) begin
      drive(1, words[i], 0);
      n_total++;
      if (locked !== (i == 3)) $display("[TB] FAIL acquire_locked_w%0d: got %0b want %0b", i, locked, (i == 3));
      else n_pass++;
    end
    n_total++; if (state !== 2'd1) $display("[TB] FAIL acquire_state: got %0d want 1", state); else n_pass++;
    n_total++; if (err_count !== 16'd0) $display("[TB] FAIL acquire_err_count: got %0d want 0", err_count); else n_pass++;
  endtask

  task automatic test_single_error();
    logic [3:0] words [3];
    words = '{4'b1111, 4'b0110, 4'b1101};
    for (int i = 0; i < 3; i++) begin
      drive(1, words[i], 0);
      n_total++;
      if (err_pulse !== (i == 0)) $display("[TB] FAIL single_err_pulse_w%0d: got %0b want %0b", i, err_pulse, (i == 0));
      else n_pass++;
      n_total++; if (err_count !== 16'd1) $display("[TB] FAIL single_err_count_w%0d: got %0d want 1", i, err_count); else n_pass++;
      n_total++; if (locked !== 1'b1) $display("[TB] FAIL single_locked_w%0d: got %0b want 1", i, locked); else n_pass++;
    end
  endtask

  task automatic test_unlock();
    logic [3:0] w;
    int s;
    do_reset();
    acquire_from(0);
    for (int i = 0; i < 4; i++) begin
      do w = 4'($urandom); while (w == seq[m_pos]);
      drive(1, w, 0);
      n_total++; if (err_pulse !== 1'b1) $display("[TB] FAIL unlock_err_pulse_w%0d: got %0b want 1", i, err_pulse); else n_pass++;
      n_total++; if (err_count !== 16'(i + 1)) $display("[TB] FAIL unlock_err_count_w%0d: got %0d want %0d", i, err_count, i + 1); else n_pass++;
      n_total++;
      if (locked !== (i != 3)) $display("[TB] FAIL unlock_locked_w%0d: got %0b want %0b", i, locked, (i != 3));
      else n_pass++;
    end
    n_total++; if (state !== 2'd0) $display("[TB] FAIL unlock_state: got %0d want 0", state); else n_pass++;
    s = $urandom_range(0, PERIOD - 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, seq[(s + i) % PERIOD], 0);
      n_total++;
      if (locked !== (i == 3)) $display("[TB] FAIL relock_locked_w%0d: got %0b want %0b", i, locked, (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_period();
    int k, pulses, gap, p;
    do_reset();
    acquire_from(0);
    k = 0; pulses = 0; p = 4;
    while (k < 30) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        drive(0, 4'($urandom), 0);
        n_total++; if (period_done !== 1'b0) $display("[TB] FAIL period_gap_pulse_k%0d: got %0b want 0", k, period_done); else n_pass++;
      end
      drive(1, seq[p], 0);
      p = (p + 1) % PERIOD;
      k++;
      if (period_done === 1'b1) pulses++;
      n_total++;
      if (period_done !== (k == 15 || k == 30)) $display("[TB] FAIL period_done_k%0d: got %0b want %0b", k, period_done, (k == 15 || k == 30));
      else n_pass++;
    end
    n_total++; if (pulses != 2) $display("[TB] FAIL period_pulse_total: got %0d want 2", pulses); else n_pass++;
    n_total++; if (err_count !== 16'd0) $display("[TB] FAIL period_err_count: got %0d want 0", err_count); else n_pass++;
  endtask

  task automatic test_zero_words();
    int seen_lock;
    do_reset();
    seen_lock = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 4'd0, 0);
      if (locked !== 1'b0) seen_lock++;
    end
    n_total++; if (seen_lock != 0) $display("[TB] FAIL zero_locked: got %0d locked cycles want 0", seen_lock); else n_pass++;
    n_total++; if (err_count !== 16'd0) $display("[TB] FAIL zero_err_count: got %0d want 0", err_count); else n_pass++;
    n_total++; if (state !== 2'd0) $display("[TB] FAIL zero_state: got %0d want 0", state); else n_pass++;
  endtask

  task automatic test_clear();
    do_reset();
    acquire_from(3);
    drive(1, ~seq[m_pos], 0);
    drive(1, ~seq[m_pos], 0);
    n_total++; if (err_count !== 16'd2) $display("[TB] FAIL clear_pre_err_count: got %0d want 2", err_count); else n_pass++;
    n_total++; if (locked !== 1'b1) $display("[TB] FAIL clear_pre_locked: got %0b want 1", locked); else n_pass++;
    drive(1, seq[m_pos], 1);
    n_total++; if (locked !== 1'b0) $display("[TB] FAIL clear_locked: got %0b want 0", locked); else n_pass++;
    n_total++; if (err_count !== 16'd0) $display("[TB] FAIL clear_err_count: got %0d want 0", err_count); else n_pass++;
    n_total++; if (period_done !== 1'b0) $display("[TB] FAIL clear_period_done: got %0b want 0", period_done); else n_pass++;
    n_total++; if (state !== 2'd0) $display("[TB] FAIL clear_state: got %0d want 0", state); else n_pass++;
    drive(0, 4'd0, 0);
    acquire_from(7);
    drive(1, ~seq[m_pos], 0);
    @(negedge clk);
    reset = 1; bus.data_valid = 1; bus.data_in = seq[m_pos];
    @(posedge clk);
    #1;
    model_reset();
    n_total++; if (locked !== 1'b0) $display("[TB] FAIL rst_mid_locked: got %0b want 0", locked); else n_pass++;
    n_total++; if (err_count !== 16'd0) $display("[TB] FAIL rst_mid_err_count: got %0d want 0", err_count); else n_pass++;
    n_total++; if (period_done !== 1'b0) $display("[TB] FAIL rst_mid_period_done: got %0b want 0", period_done); else n_pass++;
    n_total++; if (state !== 2'd0) $display("[TB] FAIL rst_mid_state: got %0d want 0", state); else n_pass++;
    @(negedge clk);
    reset = 0; bus.data_valid = 0;
  endtask

  task automatic test_random_soak();
    int g, r, errp;
    bit v, c;
    logic [3:0] w;
    do_reset();
    g = $urandom_range(0, PERIOD - 1);
    for (int i = 0; i < 400; i++) begin
      errp = (i < 200) ? 6 : 35;
      v = ($urandom_range(0, 99) < 80);
      c = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 99);
      if (r < errp) w = 4'($urandom);
      else if (r < errp + 2) w = 4'd0;
      else w = seq[g];
      if (v) g = (g + 1) % PERIOD;
      drive(v, w, c);
      n_total++; if (locked !== m_locked) $display("[TB] FAIL soak_locked_c%0d: got %0b want %0b", i, locked, m_locked); else n_pass++;
      n_total++; if (err_pulse !== m_errp) $display("[TB] FAIL soak_err_pulse_c%0d: got %0b want %0b", i, err_pulse, m_errp); else n_pass++;
      n_total++; if (err_count !== 16'(m_errs)) $display("[TB] FAIL soak_err_count_c%0d: got %0d want %0d", i, err_count, m_errs); else n_pass++;
      n_total++; if (period_done !== m_pd) $display("[TB] FAIL soak_period_done_c%0d: got %0b want %0b", i, period_done, m_pd); else n_pass++;
      n_total++; if (state !== (m_locked ? 2'd1 : 2'd0)) $display("[TB] FAIL soak_state_c%0d: got %0d want %0d", i, state, m_locked); else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    reset = 1; clear = 0; bus.data_valid = 0; bus.data_in = '0;
    model_reset();
    test_reset();
    test_acquire();
    test_single_error();
    test_unlock();
    test_period();
    test_zero_words();
    test_clear();
    test_random_soak();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
